subtractor_8bit_serial: RTL and testbench
=========================================

Name: subtractor_8bit_serial

Overview:
- Bit-serial unsigned/two's-complement subtractor: computes S = A - B one bit per clock, LSB first, under a start/busy/done handshake.
- Counterpart to the combinational ripple adder. The traffic-light controller uses it to decrement phase timers and compare elapsed time against limits without a second parallel adder chain.
- Operands are captured on start. The result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled high in IDLE launches an operation.
- A  input  WIDTH  minuend; sampled only on the accepted start edge.
- B  input  WIDTH  subtrahend; sampled only on the accepted start edge.
- S  output  WIDTH  difference A - B modulo 2^WIDTH; registered.
- Bout  output  1  final borrow; 1 when A < B unsigned.
- V  output  1  signed overflow: (A[MSB] != B[MSB]) && (S[MSB] != A[MSB]).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S/Bout/V are updated.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low, named clk and rst_n.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; S=0, Bout=0, V=0, busy=0, done=0.
  - Shift registers, borrow and bit counter cleared; the in-flight operation is discarded.
- States: IDLE, SHIFT, DONE (binary encoded; the unused encoding returns to IDLE).
- IDLE:
  - busy=0, done=0.
  - On the edge where start=1: load a_sh<=A, b_sh<=B, bw<=0, cnt<=0, latch msb flags A[MSB], B[MSB]; state<=SHIFT, busy<=1.
  - start=0 holds IDLE.
- SHIFT, each edge:
  - d = a_sh[0]^b_sh[0]^bw.
  - bw_next = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bw).
  - Result register r shifts right with d entering at MSB; a_sh and b_sh shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1 (the WIDTH-th bit):
    - S<={d, r[WIDTH-1:1]}, Bout<=bw_next, V computed from latched msb flags and the final d.
    - done<=1, busy<=0, state<=DONE.
- DONE: exactly one cycle. done<=0, state<=IDLE. start during DONE is ignored and not queued.
- Latency: start accepted at edge k → busy high from k to k+WIDTH → done high for the cycle after edge k+WIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy=1 or in DONE: ignored. A and B changes during SHIFT have no effect.
- S, Bout and V change only on the completion edge or on reset. They hold between operations.
- Wrap-around: 0 - 1 gives S=all ones, Bout=1. Equal operands give S=0, Bout=0.
- cnt width is clog2(WIDTH)+1. No out-of-range count is reachable.

Test Plan:
- Reset, then A=8'd20, B=8'd7, start for 1 cycle → busy high 8 cycles; done pulse at cycle 9 after the start edge; S=8'd13, Bout=0, V=0.
- A=8'd0, B=8'd1 → S=8'hFF, Bout=1, V=0. A=8'd55, B=8'd55 → S=0, Bout=0.
- Signed overflow: A=8'h80, B=8'h01 → S=8'h7F, Bout=0, V=1. A=8'h7F, B=8'hFF → S=8'h80, Bout=1, V=1.
- Hold start=1 continuously with A/B changing every cycle:
  - only IDLE edges launch;
  - results match operands sampled at each launch edge;
  - done pulses exactly every WIDTH+2 cycles;
  - S is stable between pulses.
- Assert rst_n=0 asynchronously at bit 4 of A=8'd200, B=8'd100 → all outputs 0 immediately, no done pulse. After release, a new start of 9-3 yields S=6 on schedule.
- Randomized 500 operations versus a reference model of A-B, including WIDTH=4 and WIDTH=16 builds → S, Bout and V match every done pulse.

Source files
------------

// File: rtl/subtractor_8bit_serial.sv
// Bit-serial subtractor: S = A - B, one bit per clock, LSB first.
// Start/busy/done handshake; results hold until the next completed operation.
module subtractor_8bit_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r;
  logic             bw;
  logic [CntW-1:0]  cnt;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             bw_next;
  logic [WIDTH-1:0] r_full;

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ bw;
    bw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    // New bit enters at the MSB; r only needs the WIDTH-1 bits collected so far.
    r_full  = {d, r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      a_sh  <= '0;
      b_sh  <= '0;
      r     <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      S     <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            bw    <= 1'b0;
            cnt   <= '0;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            busy  <= 1'b1;
            state <= StShift;
          end
        end
        StShift: begin
          r    <= r_full[WIDTH-1:1];
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bw   <= bw_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CntLast) begin
            S     <= r_full;
            Bout  <= bw_next;
            V     <= (a_msb ^ b_msb) & (d ^ a_msb);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_8bit_serial.sv
// Directed-vector, continuous-start, async-reset and random checks of the serial subtractor.
module tb_subtractor_8bit_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] S;
  logic         Bout;
  logic         V;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_s = '0;

  subtractor_8bit_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .Bout  (Bout),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         bout;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         bout;
    logic         v;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference via integer arithmetic; overflow judged by the signed result range.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    int sa, sb, diff;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    diff = sa - sb;
    res.s = a - b;
    res.bout = (a < b);
    res.v = (diff > (1 << (W - 1)) - 1) || (diff < -(1 << (W - 1)));
    return res;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic eb, input logic ev,
                       input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy_at_launch"}, busy, 1);
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1;
    end
    check({tag, " latency"}, n, W);
    check({tag, " S"}, S, es);
    check({tag, " Bout"}, Bout, eb);
    check({tag, " V"}, V, ev);
    last_s = es;
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t   tv;
    res_t   m;
    res_t   cm;
    int     ph;
    logic [W-1:0] cap_a, cap_b, ra, rb;
    int     pulses;
    int     total;

    vecs[0] = '{a: 8'd20,  b: 8'd7,   s: 8'd13,  bout: 1'b0, v: 1'b0};
    vecs[1] = '{a: 8'd0,   b: 8'd1,   s: 8'hFF,  bout: 1'b1, v: 1'b0};
    vecs[2] = '{a: 8'd55,  b: 8'd55,  s: 8'h00,  bout: 1'b0, v: 1'b0};
    vecs[3] = '{a: 8'h80,  b: 8'h01,  s: 8'h7F,  bout: 1'b0, v: 1'b1};
    vecs[4] = '{a: 8'h7F,  b: 8'hFF,  s: 8'h80,  bout: 1'b1, v: 1'b1};
    vecs[5] = '{a: 8'hFF,  b: 8'h00,  s: 8'hFF,  bout: 1'b0, v: 1'b0};
    vecs[6] = '{a: 8'h00,  b: 8'h80,  s: 8'h80,  bout: 1'b1, v: 1'b1};
    vecs[7] = '{a: 8'h01,  b: 8'hFF,  s: 8'h02,  bout: 1'b1, v: 1'b0};

    #12;
    check("reset S", S, 0);
    check("reset Bout", Bout, 0);
    check("reset V", V, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      tv = vecs[i];
      do_op(tv.a, tv.b, tv.s, tv.bout, tv.v, $sformatf("vec%0d", i));
    end

    // start held high with operands changing every cycle
    ph = 0;
    pulses = 0;
    cap_a = '0;
    cap_b = '0;
    total = 5 * (W + 2) + W + 3;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      start = (c < 5 * (W + 2));
      A = W'($urandom);
      B = W'($urandom);
      @(posedge clk);
      if (ph == 0) begin
        if (start) begin
          cap_a = A;
          cap_b = B;
          ph = 1;
        end
      end else if (ph <= W) begin
        ph++;
      end else begin
        ph = 0;
      end
      #1;
      check("cont busy", busy, (ph >= 1 && ph <= W));
      check("cont done", done, (ph == W + 1));
      if (ph == W + 1) begin
        cm = model(cap_a, cap_b);
        check("cont S", S, cm.s);
        check("cont Bout", Bout, cm.bout);
        check("cont V", V, cm.v);
        last_s = cm.s;
        pulses++;
      end else begin
        check("cont S_hold", S, last_s);
      end
    end
    check("cont pulses", pulses, 5);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    A = 8'd200;
    B = 8'd100;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst S", S, 0);
    check("arst Bout", Bout, 0);
    check("arst V", V, 0);
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    for (int c = 0; c < W + 2; c++) begin
      @(posedge clk);
      #1;
      check("arst no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      @(posedge clk);
      #1;
      check("post_rst idle_done", done, 0);
    end
    do_op(8'd9, 8'd3, 8'd6, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) rb = ra;
      m = model(ra, rb);
      do_op(ra, rb, m.s, m.bout, m.v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
